result_bus_arbiter: RTL and testbench
=====================================

// Module: result_bus_arbiter
// PURPOSE
//   Downstream of the issue queue, after the functional units. Collects completed results from
//   NUM_FU functional units into small per-FU FIFOs. Round-robin arbitration picks one result per
//   cycle to drive onto the common result bus. The bus feeds the issue-queue forward inputs
//   (fwd_rd/fwd_rd_val) and the ROB completion port.
// PARAMETERS
//   NUM_FU      3   number of functional units / result sources
//   DATA_W      32  result value width
//   PREG_W      6   physical register index width
//   ROB_W       6   ROB entry index width
//   FIFO_DEPTH  2   entries per FU result FIFO (power of 2, >=2)
//   IDLE_PREG   6'b111111  value driven on cdb_rd when the bus is idle
// PORTS
//   clk              in   1               clock, rising edge
//   reset_n          in   1               asynchronous reset, active-low
//   flush            in   1               synchronous: discard all buffered results
//   fu_valid         in   NUM_FU          FU i presents a result this cycle
//   fu_rd            in   NUM_FU*PREG_W   dest phys reg, FU i in slice [i*PREG_W +: PREG_W]
//   fu_val           in   NUM_FU*DATA_W   result value, slice [i*DATA_W +: DATA_W]
//   fu_rob           in   NUM_FU*ROB_W    ROB index, slice [i*ROB_W +: ROB_W]
//   fu_ready         out  NUM_FU          FIFO i can accept (combinational: count_i != FIFO_DEPTH)
//   cdb_valid        out  1               registered: result on bus this cycle
//   cdb_rd           out  PREG_W          registered dest phys reg; IDLE_PREG when !cdb_valid
//   cdb_val          out  DATA_W          registered value; 0 when !cdb_valid
//   cdb_rob          out  ROB_W           registered ROB index; 0 when !cdb_valid
//   cdb_fu           out  2               registered source FU id; 0 when !cdb_valid
//   fu_pending       out  NUM_FU          FIFO i non-empty
// BEHAVIOUR
//   Reset (async):
//   - All FIFOs empty; rr_ptr = 0.
//   - cdb_valid = 0, cdb_rd = IDLE_PREG, cdb_val = 0, cdb_rob = 0, cdb_fu = 0.
//   - fu_ready = all 1s; fu_pending = 0.
//   Enqueue:
//   - On a rising edge with fu_valid[i] && fu_ready[i], push {rd, val, rob} into FIFO i.
//   - fu_valid[i] while !fu_ready[i] is dropped. This is a protocol violation; the FU must hold
//     its result.
//   Ready rule:
//   - fu_ready[i] depends only on the current count. A full FIFO shows ready=0 even in a cycle
//     where it is popped (no same-cycle bypass).
//   Arbitration:
//   - Each cycle, candidates = FIFOs non-empty at the start of the cycle.
//   - Grant the first candidate found scanning i = rr_ptr, rr_ptr+1, ... modulo NUM_FU.
//   - On a grant: pop that FIFO head, register it onto cdb_* at the edge, and set
//     rr_ptr = (granted + 1) % NUM_FU.
//   - No candidate: cdb_valid = 0, idle values are driven, rr_ptr is unchanged.
//   Latency:
//   - Minimum 2 edges from FU handshake to cdb_valid (edge 1 enqueue, edge 2 bus register).
//   - Throughput is 1 result per cycle across all FUs.
//   - A value enqueued at edge N is never granted at edge N.
//   Idle bus:
//   - cdb_rd must be IDLE_PREG whenever cdb_valid = 0. Downstream comparators match on rd alone
//     and must never see a stale tag.
//   Simultaneous push and pop on one FIFO: count unchanged, pointers both advance, order kept.
//   Order:
//   - Results from a single FU leave in arrival order.
//   - No ordering is guaranteed between different FUs.
//   Pointer wrap: FIFO rd/wr pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is a
//   separate register of log2(FIFO_DEPTH)+1 bits.
//   Flush (sync):
//   - At the edge, all counts and pointers go to 0 and cdb_* take idle values.
//   - Pushes in the flush cycle are discarded. rr_ptr is kept.
//   - flush has priority over push and pop.
//   Reset mid-operation: buffered results are lost; outputs return to reset values immediately.
// TESTING
//   1. Reset, then FU0 pushes rd=5, val=0xDEADBEEF, rob=3 at edge 1
//      -> edge 2: cdb_valid=1, rd=5, val=0xDEADBEEF, rob=3, cdb_fu=0; edge 3: cdb_valid=0, rd=0x3F.
//   2. All 3 FUs push one result at the same edge, rr_ptr=0
//      -> bus shows FU0, FU1, FU2 on 3 consecutive cycles; rr_ptr ends at 0.
//   3. FU1 pushes rd=7 and rd=8 back-to-back while the bus is blocked by a continuous FU0 stream
//      -> fu_ready[1]=0 after the 2nd push; a third valid is dropped; 7 leaves before 8.
//   4. FU2 FIFO full, pop and push in the same cycle -> fu_ready[2] was 0, so push not accepted;
//      count goes 2->1; next cycle fu_ready[2]=1.
//   5. Two results buffered, flush=1 with a concurrent FU0 push -> next edge: cdb_valid=0,
//      fu_pending=0, fu_ready=3'b111, nothing ever appears on the bus.
//   6. Assert reset_n=0 asynchronously mid-stream -> cdb_valid drops to 0 and cdb_rd to 0x3F
//      without a clock edge.

Source files
------------

// File: rtl/result_bus_arbiter.sv
// Result bus arbiter: per-FU result FIFOs drained onto one common result bus
// by a round-robin arbiter. The bus feeds the issue-queue forwarding inputs and
// the ROB completion port. When the bus is idle it carries IDLE_PREG on cdb_rd,
// so downstream tag comparators never match a stale register.
module result_bus_arbiter #(
  parameter int                NUM_FU     = 3,
  parameter int                DATA_W     = 32,
  parameter int                PREG_W     = 6,
  parameter int                ROB_W      = 6,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [PREG_W-1:0] IDLE_PREG  = {PREG_W{1'b1}}
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic [NUM_FU-1:0]          fu_valid,
  input  logic [NUM_FU*PREG_W-1:0]   fu_rd,
  input  logic [NUM_FU*DATA_W-1:0]   fu_val,
  input  logic [NUM_FU*ROB_W-1:0]    fu_rob,
  output logic [NUM_FU-1:0]          fu_ready,
  output logic                       cdb_valid,
  output logic [PREG_W-1:0]          cdb_rd,
  output logic [DATA_W-1:0]          cdb_val,
  output logic [ROB_W-1:0]           cdb_rob,
  output logic [1:0]                 cdb_fu,
  output logic [NUM_FU-1:0]          fu_pending
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int ENT_W = PREG_W + DATA_W + ROB_W;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W:0]   NUM_FU_C = (IDX_W + 1)'(NUM_FU);
  localparam logic [IDX_W-1:0] LAST_FU  = IDX_W'(NUM_FU - 1);

  // Entry layout is {rd, val, rob}.
  logic [ENT_W-1:0]  mem_q    [NUM_FU][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_FU];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_FU];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_FU];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_FU];
  logic [CNT_W-1:0]  cnt_q    [NUM_FU];
  logic [CNT_W-1:0]  cnt_d    [NUM_FU];
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic              gnt_valid_s;
  logic [IDX_W-1:0]  gnt_idx_s;
  logic [IDX_W:0]    scan_s;
  logic [NUM_FU-1:0] push_s, pop_s;

  logic              cdb_valid_q, cdb_valid_d;
  logic [PREG_W-1:0] cdb_rd_q, cdb_rd_d;
  logic [DATA_W-1:0] cdb_val_q, cdb_val_d;
  logic [ROB_W-1:0]  cdb_rob_q, cdb_rob_d;
  logic [1:0]        cdb_fu_q, cdb_fu_d;

  // Ready and pending come straight from the stored counts (no pop bypass).
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i]   = (cnt_q[i] != DEPTH_C);
      fu_pending[i] = (cnt_q[i] != '0);
    end
  end

  // Round-robin scan starting at rr_ptr over FIFOs non-empty before this edge.
  always_comb begin
    gnt_valid_s = 1'b0;
    gnt_idx_s   = '0;
    scan_s      = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_s = {1'b0, rr_ptr_q} + (IDX_W + 1)'(k);
      if (scan_s >= NUM_FU_C) begin
        scan_s = scan_s - NUM_FU_C;
      end else begin
        scan_s = scan_s;
      end
      if (!gnt_valid_s && (cnt_q[scan_s[IDX_W-1:0]] != '0)) begin
        gnt_valid_s = 1'b1;
        gnt_idx_s   = scan_s[IDX_W-1:0];
      end else begin
        gnt_valid_s = gnt_valid_s;
      end
    end
  end

  // FIFO pointer/count next state; flush wins over both push and pop.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      push_s[i] = fu_valid[i] & fu_ready[i] & ~flush;
      pop_s[i]  = gnt_valid_s & (gnt_idx_s == IDX_W'(i)) & ~flush;
      if (flush) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(push_s[i]);
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(pop_s[i]);
        case ({push_s[i], pop_s[i]})
          2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
          2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
          default: cnt_d[i] = cnt_q[i];
        endcase
      end
    end
  end

  // Bus next state: granted head or idle values; rr_ptr moves past the winner.
  always_comb begin
    cdb_valid_d = 1'b0;
    cdb_rd_d    = IDLE_PREG;
    cdb_val_d   = '0;
    cdb_rob_d   = '0;
    cdb_fu_d    = 2'd0;
    rr_ptr_d    = rr_ptr_q;
    if (!flush && gnt_valid_s) begin
      cdb_valid_d                        = 1'b1;
      {cdb_rd_d, cdb_val_d, cdb_rob_d}   = mem_q[gnt_idx_s][rd_ptr_q[gnt_idx_s]];
      cdb_fu_d                           = 2'(gnt_idx_s);
      rr_ptr_d                           = (gnt_idx_s == LAST_FU) ? '0 : gnt_idx_s + IDX_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Result storage; contents are don't-care until a count covers them.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (push_s[i]) begin
        mem_q[i][wr_ptr_q[i]] <= {fu_rd[i*PREG_W +: PREG_W],
                                  fu_val[i*DATA_W +: DATA_W],
                                  fu_rob[i*ROB_W +: ROB_W]};
      end
    end
  end

  // Control state and registered bus outputs with asynchronous reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      rr_ptr_q    <= '0;
      cdb_valid_q <= 1'b0;
      cdb_rd_q    <= IDLE_PREG;
      cdb_val_q   <= '0;
      cdb_rob_q   <= '0;
      cdb_fu_q    <= 2'd0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      rr_ptr_q    <= rr_ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_rd_q    <= cdb_rd_d;
      cdb_val_q   <= cdb_val_d;
      cdb_rob_q   <= cdb_rob_d;
      cdb_fu_q    <= cdb_fu_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_rd    = cdb_rd_q;
  assign cdb_val   = cdb_val_q;
  assign cdb_rob   = cdb_rob_q;
  assign cdb_fu    = cdb_fu_q;

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Testbench for result_bus_arbiter: directed vector table, hand-written
// multi-cycle sequences and random traffic against a queue-based model.
module tb_result_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  fu_valid = 3'b000;
  logic [17:0] fu_rd = 18'd0;
  logic [95:0] fu_val = 96'd0;
  logic [17:0] fu_rob = 18'd0;
  logic [2:0]  fu_ready;
  logic        cdb_valid;
  logic [5:0]  cdb_rd;
  logic [31:0] cdb_val;
  logic [5:0]  cdb_rob;
  logic [1:0]  cdb_fu;
  logic [2:0]  fu_pending;

  result_bus_arbiter dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .fu_valid(fu_valid), .fu_rd(fu_rd), .fu_val(fu_val), .fu_rob(fu_rob),
    .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_rd(cdb_rd),
    .cdb_val(cdb_val), .cdb_rob(cdb_rob), .cdb_fu(cdb_fu),
    .fu_pending(fu_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one queue per FU of {rd, val, rob}, plus the rr pointer.
  logic [43:0] mq [3][$];
  int          rr = 0;
  logic        e_valid;
  logic [5:0]  e_rd;
  logic [31:0] e_val;
  logic [5:0]  e_rob;
  logic [1:0]  e_fu;
  logic [5:0]  fu1_seen [$];

  typedef struct {
    logic [2:0]  v;
    logic [17:0] rd;
    logic [95:0] val;
    logic [17:0] rob;
    logic        fl;
    logic        ev;
    logic [5:0]  erd;
    logic [31:0] eval;
    logic [5:0]  erob;
    logic [1:0]  efu;
    logic [2:0]  erdy;
    logic [2:0]  epend;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t row(logic [2:0] v, logic [17:0] rd, logic [95:0] val,
                               logic [17:0] rob, logic fl, logic ev, logic [5:0] erd,
                               logic [31:0] eval, logic [5:0] erob, logic [1:0] efu,
                               logic [2:0] erdy, logic [2:0] epend);
    vec_t r;
    r.v = v; r.rd = rd; r.val = val; r.rob = rob; r.fl = fl;
    r.ev = ev; r.erd = erd; r.eval = eval; r.erob = erob; r.efu = efu;
    r.erdy = erdy; r.epend = epend;
    return r;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) mq[i].delete();
    rr = 0;
    e_valid = 1'b0; e_rd = 6'h3F; e_val = 32'd0; e_rob = 6'd0; e_fu = 2'd0;
  endtask

  task automatic drive_idle();
    fu_valid = 3'b000; fu_rd = 18'd0; fu_val = 96'd0; fu_rob = 18'd0; flush = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
    #1;
    chk("rst_valid", {95'd0, cdb_valid}, 96'd0);
    chk("rst_rd", {90'd0, cdb_rd}, 96'h3F);
    chk("rst_val", {64'd0, cdb_val}, 96'd0);
    chk("rst_rob", {90'd0, cdb_rob}, 96'd0);
    chk("rst_fu", {94'd0, cdb_fu}, 96'd0);
    chk("rst_ready", {93'd0, fu_ready}, 96'h7);
    chk("rst_pending", {93'd0, fu_pending}, 96'd0);
  endtask

  // One clock: advance the model from the current inputs, then compare the DUT.
  task automatic cycle();
    logic [2:0]  acc;
    logic [2:0]  x_rdy;
    logic [2:0]  x_pend;
    logic [43:0] e;
    int          g;
    for (int i = 0; i < 3; i++) acc[i] = fu_valid[i] && (mq[i].size() < 2) && !flush;
    g = -1;
    for (int k = 0; k < 3; k++) begin
      if (g < 0 && mq[(rr + k) % 3].size() > 0) g = (rr + k) % 3;
    end
    e_valid = 1'b0; e_rd = 6'h3F; e_val = 32'd0; e_rob = 6'd0; e_fu = 2'd0;
    if (flush) begin
      for (int i = 0; i < 3; i++) mq[i].delete();
    end else begin
      if (g >= 0) begin
        e = mq[g].pop_front();
        e_valid = 1'b1; e_rd = e[43:38]; e_val = e[37:6]; e_rob = e[5:0]; e_fu = 2'(g);
        rr = (g + 1) % 3;
      end
      for (int i = 0; i < 3; i++)
        if (acc[i]) mq[i].push_back({fu_rd[i*6 +: 6], fu_val[i*32 +: 32], fu_rob[i*6 +: 6]});
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      x_rdy[i]  = (mq[i].size() < 2);
      x_pend[i] = (mq[i].size() > 0);
    end
    chk("cdb_valid", {95'd0, cdb_valid}, {95'd0, e_valid});
    chk("cdb_rd", {90'd0, cdb_rd}, {90'd0, e_rd});
    chk("cdb_val", {64'd0, cdb_val}, {64'd0, e_val});
    chk("cdb_rob", {90'd0, cdb_rob}, {90'd0, e_rob});
    chk("cdb_fu", {94'd0, cdb_fu}, {94'd0, e_fu});
    chk("fu_ready", {93'd0, fu_ready}, {93'd0, x_rdy});
    chk("fu_pending", {93'd0, fu_pending}, {93'd0, x_pend});
    if (cdb_valid && cdb_fu == 2'd1) fu1_seen.push_back(cdb_rd);
  endtask

  task automatic set_fu(input int i, input logic [5:0] rd, input logic [31:0] val,
                        input logic [5:0] rob);
    fu_valid[i] = 1'b1;
    fu_rd[i*6 +: 6] = rd;
    fu_val[i*32 +: 32] = val;
    fu_rob[i*6 +: 6] = rob;
  endtask

  initial begin
    tbl[0]  = row(3'b111, {6'd12, 6'd11, 6'd10}, {32'h102, 32'h101, 32'h100},
                  {6'd22, 6'd21, 6'd20}, 1'b0, 1'b0, 6'h3F, 32'h0, 6'd0, 2'd0, 3'b111, 3'b111);
    tbl[1]  = row(3'b000, 18'd0, 96'd0, 18'd0, 1'b0, 1'b1, 6'd10, 32'h100, 6'd20, 2'd0, 3'b111, 3'b110);
    tbl[2]  = row(3'b000, 18'd0, 96'd0, 18'd0, 1'b0, 1'b1, 6'd11, 32'h101, 6'd21, 2'd1, 3'b111, 3'b100);
    tbl[3]  = row(3'b000, 18'd0, 96'd0, 18'd0, 1'b0, 1'b1, 6'd12, 32'h102, 6'd22, 2'd2, 3'b111, 3'b000);
    tbl[4]  = row(3'b001, {12'd0, 6'd5}, {64'd0, 32'hDEADBEEF}, {12'd0, 6'd3}, 1'b0,
                  1'b0, 6'h3F, 32'h0, 6'd0, 2'd0, 3'b111, 3'b001);
    tbl[5]  = row(3'b000, 18'd0, 96'd0, 18'd0, 1'b0, 1'b1, 6'd5, 32'hDEADBEEF, 6'd3, 2'd0, 3'b111, 3'b000);
    tbl[6]  = row(3'b000, 18'd0, 96'd0, 18'd0, 1'b0, 1'b0, 6'h3F, 32'h0, 6'd0, 2'd0, 3'b111, 3'b000);
    tbl[7]  = row(3'b100, {6'd1, 12'd0}, {32'hA, 64'd0}, {6'd1, 12'd0}, 1'b0,
                  1'b0, 6'h3F, 32'h0, 6'd0, 2'd0, 3'b111, 3'b100);
    tbl[8]  = row(3'b101, {6'd3, 6'd0, 6'd2}, {32'hC, 32'h0, 32'hB}, {6'd3, 6'd0, 6'd2}, 1'b0,
                  1'b1, 6'd1, 32'hA, 6'd1, 2'd2, 3'b111, 3'b101);
    tbl[9]  = row(3'b001, {12'd0, 6'd9}, {64'd0, 32'h99}, {12'd0, 6'd9}, 1'b1,
                  1'b0, 6'h3F, 32'h0, 6'd0, 2'd0, 3'b111, 3'b000);
    tbl[10] = row(3'b000, 18'd0, 96'd0, 18'd0, 1'b0, 1'b0, 6'h3F, 32'h0, 6'd0, 2'd0, 3'b111, 3'b000);
    tbl[11] = row(3'b010, {6'd0, 6'd4, 6'd0}, {32'h0, 32'hD, 32'h0}, {6'd0, 6'd4, 6'd0}, 1'b0,
                  1'b0, 6'h3F, 32'h0, 6'd0, 2'd0, 3'b111, 3'b010);
    tbl[12] = row(3'b000, 18'd0, 96'd0, 18'd0, 1'b0, 1'b1, 6'd4, 32'hD, 6'd4, 2'd1, 3'b111, 3'b000);

    // Directed table: round-robin order, latency, idle tag, flush with push.
    do_reset();
    for (int n = 0; n < 13; n++) begin
      fu_valid = tbl[n].v; fu_rd = tbl[n].rd; fu_val = tbl[n].val;
      fu_rob = tbl[n].rob; flush = tbl[n].fl;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", n), {95'd0, cdb_valid}, {95'd0, tbl[n].ev});
      chk($sformatf("tbl%0d_rd", n), {90'd0, cdb_rd}, {90'd0, tbl[n].erd});
      chk($sformatf("tbl%0d_val", n), {64'd0, cdb_val}, {64'd0, tbl[n].eval});
      chk($sformatf("tbl%0d_rob", n), {90'd0, cdb_rob}, {90'd0, tbl[n].erob});
      chk($sformatf("tbl%0d_fu", n), {94'd0, cdb_fu}, {94'd0, tbl[n].efu});
      chk($sformatf("tbl%0d_ready", n), {93'd0, fu_ready}, {93'd0, tbl[n].erdy});
      chk($sformatf("tbl%0d_pending", n), {93'd0, fu_pending}, {93'd0, tbl[n].epend});
    end
    drive_idle();

    // FU1 fills while FU0 streams; third FU1 valid is dropped, 7 before 8.
    do_reset();
    fu1_seen.delete();
    set_fu(0, 6'd20, 32'h20, 6'd20); set_fu(1, 6'd7, 32'h7, 6'd7); cycle();
    set_fu(0, 6'd21, 32'h21, 6'd21); set_fu(1, 6'd8, 32'h8, 6'd8); cycle();
    chk("fu1_full_ready", {95'd0, fu_ready[1]}, 96'd0);
    set_fu(0, 6'd22, 32'h22, 6'd22); set_fu(1, 6'd9, 32'h9, 6'd9); cycle();
    fu_valid[1] = 1'b0;
    set_fu(0, 6'd23, 32'h23, 6'd23); cycle();
    drive_idle();
    repeat (6) cycle();
    chk("fu1_count", 96'(fu1_seen.size()), 96'd2);
    if (fu1_seen.size() == 2) begin
      chk("fu1_first", {90'd0, fu1_seen[0]}, 96'd7);
      chk("fu1_second", {90'd0, fu1_seen[1]}, 96'd8);
    end else begin
      chk("fu1_order_len", 96'(fu1_seen.size()), 96'd2);
    end

    // FU2 full: pop and offered push in the same cycle, push not taken.
    do_reset();
    set_fu(0, 6'd30, 32'h30, 6'd30); set_fu(1, 6'd31, 32'h31, 6'd31);
    set_fu(2, 6'd32, 32'h32, 6'd32); cycle();
    drive_idle(); set_fu(2, 6'd33, 32'h33, 6'd33); cycle();
    chk("fu2_full_a", {95'd0, fu_ready[2]}, 96'd0);
    set_fu(2, 6'd34, 32'h34, 6'd34); cycle();
    chk("fu2_full_b", {95'd0, fu_ready[2]}, 96'd0);
    cycle();
    chk("fu2_after_pop", {95'd0, fu_ready[2]}, 96'd1);
    cycle();
    drive_idle();
    repeat (4) cycle();

    // Asynchronous reset mid-stream clears the bus without a clock edge.
    do_reset();
    set_fu(0, 6'd40, 32'h40, 6'd40); set_fu(1, 6'd41, 32'h41, 6'd41); cycle();
    drive_idle(); cycle();
    chk("pre_arst_valid", {95'd0, cdb_valid}, 96'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", {95'd0, cdb_valid}, 96'd0);
    chk("arst_rd", {90'd0, cdb_rd}, 96'h3F);
    chk("arst_pending", {93'd0, fu_pending}, 96'd0);
    chk("arst_ready", {93'd0, fu_ready}, 96'h7);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      fu_valid = 3'($urandom_range(0, 7));
      fu_rd    = 18'($urandom);
      fu_val   = {$urandom, $urandom, $urandom};
      fu_rob   = 18'($urandom);
      flush    = ($urandom_range(0, 19) == 0);
      cycle();
    end
    drive_idle();
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
